// File: rtl/lsb_issue_pkg.sv
// Shared widths, op encodings and store classification for the load/store buffer issue side.
package lsb_issue_pkg;

    localparam int LSB_SIZE_DEF = 16;
    localparam int ROB_ID_W_DEF = 4;
    localparam int DATA_W_DEF   = 32;
    localparam int IMM_W_DEF    = 32;
    localparam int OPID_W_DEF   = 6;

    typedef enum logic [OPID_W_DEF-1:0] {
        OP_LB  = 6'd1,
        OP_LH  = 6'd2,
        OP_LW  = 6'd3,
        OP_LBU = 6'd4,
        OP_LHU = 6'd5,
        OP_SB  = 6'd6,
        OP_SH  = 6'd7,
        OP_SW  = 6'd8
    } lsb_op_e;

    function automatic logic is_store_op(input logic [OPID_W_DEF-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/lsb_issue_operand_snoop.sv
// One operand slot of a buffer entry: captures the dispatched value or snoops the CDB for its tag.
module lsb_operand_snoop #(
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                load,
    input  logic [DATA_W-1:0]   load_value,
    input  logic                load_ready,
    input  logic [ROB_ID_W-1:0] load_tag,
    input  logic                cdb_valid,
    input  logic [ROB_ID_W-1:0] cdb_rob_id,
    input  logic [DATA_W-1:0]   cdb_value,
    output logic [DATA_W-1:0]   value,
    output logic                ready
);

    logic [ROB_ID_W-1:0] tag;

    // A broadcast seen in the dispatch cycle is captured here, so the slot is ready one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            ready <= 1'b0;
            tag   <= '0;
        end else if (rdy) begin
            if (load) begin
                tag <= load_tag;
                if (load_ready) begin
                    value <= load_value;
                    ready <= 1'b1;
                end else if (cdb_valid && (cdb_rob_id == load_tag)) begin
                    value <= cdb_value;
                    ready <= 1'b1;
                end else begin
                    value <= load_value;
                    ready <= 1'b0;
                end
            end else if (!ready && cdb_valid && (cdb_rob_id == tag)) begin
                value <= cdb_value;
                ready <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsb_issue.sv
// In-order load/store buffer issuing the head entry to ALU_LS; stores wait for ROB commit.
// Optional issue counters stat_loads/stat_stores are built when LSB_STATS_EN is defined.
module lsb_issue
    import lsb_issue_pkg::*;
#(
    parameter int LSB_SIZE = LSB_SIZE_DEF,
    parameter int ROB_ID_W = ROB_ID_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int IMM_W    = IMM_W_DEF,
    parameter int OPID_W   = OPID_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                disp_valid,
    input  logic [OPID_W-1:0]   disp_op_id,
    input  logic                disp_is_store,
    input  logic [DATA_W-1:0]   disp_pc,
    input  logic [DATA_W-1:0]   disp_rs1_val,
    input  logic [DATA_W-1:0]   disp_rs2_val,
    input  logic                disp_rs1_rdy,
    input  logic                disp_rs2_rdy,
    input  logic [ROB_ID_W-1:0] disp_rs1_tag,
    input  logic [ROB_ID_W-1:0] disp_rs2_tag,
    input  logic [IMM_W-1:0]    disp_imm,
    input  logic [ROB_ID_W-1:0] disp_rob_id,
    output logic                lsb_full,
    input  logic                cdb_valid,
    input  logic [ROB_ID_W-1:0] cdb_rob_id,
    input  logic [DATA_W-1:0]   cdb_value,
    input  logic                commit_valid,
    input  logic [ROB_ID_W-1:0] commit_rob_id,
    input  logic                flush,
    input  logic                alu_ready,
`ifdef LSB_STATS_EN
    output logic [31:0]         stat_loads,
    output logic [31:0]         stat_stores,
`endif
    output logic                LSB_output_valid,
    output logic [OPID_W-1:0]   LSB_OP_ID,
    output logic [DATA_W-1:0]   LSB_inst_pc,
    output logic [DATA_W-1:0]   LSB_reg_rs1,
    output logic [DATA_W-1:0]   LSB_reg_rs2,
    output logic [IMM_W-1:0]    LSB_imm,
    output logic [ROB_ID_W-1:0] LSB_ROB_id
);

    localparam int PTR_W = $clog2(LSB_SIZE);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic [LSB_SIZE-1:0] valid;
    logic [LSB_SIZE-1:0] is_store;
    logic [LSB_SIZE-1:0] committed;
    logic [OPID_W-1:0]   op_id  [LSB_SIZE];
    logic [DATA_W-1:0]   pc     [LSB_SIZE];
    logic [IMM_W-1:0]    imm    [LSB_SIZE];
    logic [ROB_ID_W-1:0] rob_id [LSB_SIZE];

    logic [LSB_SIZE-1:0] rs1_ready;
    logic [LSB_SIZE-1:0] rs2_ready;
    logic [DATA_W-1:0]   rs1_val [LSB_SIZE];
    logic [DATA_W-1:0]   rs2_val [LSB_SIZE];
    logic [LSB_SIZE-1:0] load_en;

    logic enq;
    logic head_ready;
    logic issue_fire;

    logic [LSB_SIZE-1:0] keep;
    logic [CNT_W-1:0]    keep_cnt;
    logic                run;
    logic [PTR_W-1:0]    idx;

    assign lsb_full   = (count == CNT_W'(LSB_SIZE));
    assign enq        = rdy && !flush && disp_valid && !lsb_full;
    assign head_ready = valid[head] && rs1_ready[head] &&
                        (!is_store[head] || (rs2_ready[head] && committed[head]));
    assign issue_fire = rdy && !flush && head_ready && alu_ready;

    always_comb begin
        load_en = '0;
        if (enq) begin
            load_en[tail] = 1'b1;
        end
    end

    for (genvar g = 0; g < LSB_SIZE; g++) begin : g_entry
        lsb_operand_snoop #(.DATA_W(DATA_W), .ROB_ID_W(ROB_ID_W)) u_rs1 (
            .clk        (clk),
            .rst        (rst),
            .rdy        (rdy),
            .load       (load_en[g]),
            .load_value (disp_rs1_val),
            .load_ready (disp_rs1_rdy),
            .load_tag   (disp_rs1_tag),
            .cdb_valid  (cdb_valid),
            .cdb_rob_id (cdb_rob_id),
            .cdb_value  (cdb_value),
            .value      (rs1_val[g]),
            .ready      (rs1_ready[g])
        );
        lsb_operand_snoop #(.DATA_W(DATA_W), .ROB_ID_W(ROB_ID_W)) u_rs2 (
            .clk        (clk),
            .rst        (rst),
            .rdy        (rdy),
            .load       (load_en[g]),
            .load_value (disp_rs2_val),
            .load_ready (disp_rs2_rdy),
            .load_tag   (disp_rs2_tag),
            .cdb_valid  (cdb_valid),
            .cdb_rob_id (cdb_rob_id),
            .cdb_value  (cdb_value),
            .value      (rs2_val[g]),
            .ready      (rs2_ready[g])
        );
    end

    // Committed stores sit as a contiguous run from head; that run is what survives a flush.
    always_comb begin
        keep     = '0;
        keep_cnt = '0;
        run      = 1'b1;
        idx      = head;
        for (int k = 0; k < LSB_SIZE; k++) begin
            idx = head + PTR_W'(k);
            if (run && valid[idx] && committed[idx]) begin
                keep[idx] = 1'b1;
                keep_cnt  = keep_cnt + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            valid            <= '0;
            is_store         <= '0;
            committed        <= '0;
            LSB_output_valid <= 1'b0;
            LSB_OP_ID        <= '0;
            LSB_inst_pc      <= '0;
            LSB_reg_rs1      <= '0;
            LSB_reg_rs2      <= '0;
            LSB_imm          <= '0;
            LSB_ROB_id       <= '0;
            for (int i = 0; i < LSB_SIZE; i++) begin
                op_id[i]  <= '0;
                pc[i]     <= '0;
                imm[i]    <= '0;
                rob_id[i] <= '0;
            end
        end else if (rdy) begin
            if (flush) begin
                valid            <= keep;
                tail             <= head + keep_cnt[PTR_W-1:0];
                count            <= keep_cnt;
                LSB_output_valid <= 1'b0;
            end else begin
                for (int i = 0; i < LSB_SIZE; i++) begin
                    if (commit_valid && valid[i] && is_store[i] && (rob_id[i] == commit_rob_id)) begin
                        committed[i] <= 1'b1;
                    end
                end

                if (issue_fire) begin
                    LSB_output_valid <= 1'b1;
                    LSB_OP_ID        <= op_id[head];
                    LSB_inst_pc      <= pc[head];
                    LSB_reg_rs1      <= rs1_val[head];
                    LSB_reg_rs2      <= rs2_val[head];
                    LSB_imm          <= imm[head];
                    LSB_ROB_id       <= rob_id[head];
                    valid[head]      <= 1'b0;
                    head             <= head + PTR_W'(1);
                end else begin
                    LSB_output_valid <= 1'b0;
                end

                if (enq) begin
                    valid[tail]     <= 1'b1;
                    is_store[tail]  <= disp_is_store;
                    committed[tail] <= 1'b0;
                    op_id[tail]     <= disp_op_id;
                    pc[tail]        <= disp_pc;
                    imm[tail]       <= disp_imm;
                    rob_id[tail]    <= disp_rob_id;
                    tail            <= tail + PTR_W'(1);
                end

                if (enq && !issue_fire) begin
                    count <= count + CNT_W'(1);
                end else if (!enq && issue_fire) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

`ifdef LSB_STATS_EN
    // Counters survive flush; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_loads  <= '0;
            stat_stores <= '0;
        end else if (issue_fire) begin
            if (is_store[head]) begin
                stat_stores <= stat_stores + 32'd1;
            end else begin
                stat_loads <= stat_loads + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lsb_issue.sv
// Directed scoreboard bench for lsb_issue: expected issues are queued as stimulus goes in, a monitor pops them.
module tb_lsb_issue;
    import lsb_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        disp_valid;
    logic [5:0]  disp_op_id;
    logic        disp_is_store;
    logic [31:0] disp_pc;
    logic [31:0] disp_rs1_val;
    logic [31:0] disp_rs2_val;
    logic        disp_rs1_rdy;
    logic        disp_rs2_rdy;
    logic [3:0]  disp_rs1_tag;
    logic [3:0]  disp_rs2_tag;
    logic [31:0] disp_imm;
    logic [3:0]  disp_rob_id;
    logic        lsb_full;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_value;
    logic        commit_valid;
    logic [3:0]  commit_rob_id;
    logic        flush;
    logic        alu_ready;
    logic        LSB_output_valid;
    logic [5:0]  LSB_OP_ID;
    logic [31:0] LSB_inst_pc;
    logic [31:0] LSB_reg_rs1;
    logic [31:0] LSB_reg_rs2;
    logic [31:0] LSB_imm;
    logic [3:0]  LSB_ROB_id;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [3:0]  rob;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;

    lsb_issue dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .disp_valid       (disp_valid),
        .disp_op_id       (disp_op_id),
        .disp_is_store    (disp_is_store),
        .disp_pc          (disp_pc),
        .disp_rs1_val     (disp_rs1_val),
        .disp_rs2_val     (disp_rs2_val),
        .disp_rs1_rdy     (disp_rs1_rdy),
        .disp_rs2_rdy     (disp_rs2_rdy),
        .disp_rs1_tag     (disp_rs1_tag),
        .disp_rs2_tag     (disp_rs2_tag),
        .disp_imm         (disp_imm),
        .disp_rob_id      (disp_rob_id),
        .lsb_full         (lsb_full),
        .cdb_valid        (cdb_valid),
        .cdb_rob_id       (cdb_rob_id),
        .cdb_value        (cdb_value),
        .commit_valid     (commit_valid),
        .commit_rob_id    (commit_rob_id),
        .flush            (flush),
        .alu_ready        (alu_ready),
        .LSB_output_valid (LSB_output_valid),
        .LSB_OP_ID        (LSB_OP_ID),
        .LSB_inst_pc      (LSB_inst_pc),
        .LSB_reg_rs1      (LSB_reg_rs1),
        .LSB_reg_rs2      (LSB_reg_rs2),
        .LSB_imm          (LSB_imm),
        .LSB_ROB_id       (LSB_ROB_id)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // A pulse is consumed on cycles where the pipeline is enabled.
    always @(negedge clk) begin
        if (!rst && rdy && LSB_output_valid) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_issue: got rob=%0d pc=0x%0h, expected no issue", LSB_ROB_id, LSB_inst_pc);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("issue_rob", 64'(LSB_ROB_id), 64'(mon_e.rob));
                checkOutput("issue_op", 64'(LSB_OP_ID), 64'(mon_e.op));
                checkOutput("issue_pc", 64'(LSB_inst_pc), 64'(mon_e.pc));
                checkOutput("issue_rs1", 64'(LSB_reg_rs1), 64'(mon_e.rs1));
                checkOutput("issue_rs2", 64'(LSB_reg_rs2), 64'(mon_e.rs2));
                checkOutput("issue_imm", 64'(LSB_imm), 64'(mon_e.imm));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] rs1,
                            input logic [31:0] rs2, input logic [31:0] imm, input logic [3:0] rob);
        exp_t e;
        e.op = op; e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.rob = rob;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] pc,
                                 input logic [31:0] rs1v, input logic rs1r, input logic [3:0] rs1t,
                                 input logic [31:0] rs2v, input logic rs2r, input logic [3:0] rs2t,
                                 input logic [31:0] imm, input logic [3:0] rob);
        disp_op_id    = op;
        disp_is_store = is_store_op(op);
        disp_pc       = pc;
        disp_rs1_val  = rs1v;
        disp_rs1_rdy  = rs1r;
        disp_rs1_tag  = rs1t;
        disp_rs2_val  = rs2v;
        disp_rs2_rdy  = rs2r;
        disp_rs2_tag  = rs2t;
        disp_imm      = imm;
        disp_rob_id   = rob;
        disp_valid    = 1'b1;
        tick();
        disp_valid    = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] rob);
        commit_valid  = 1'b1;
        commit_rob_id = rob;
        tick();
        commit_valid  = 1'b0;
    endtask

    task automatic do_cdb(input logic [3:0] rob, input logic [31:0] val);
        cdb_valid  = 1'b1;
        cdb_rob_id = rob;
        cdb_value  = val;
        tick();
        cdb_valid  = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain_timeout: %0d issues still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; disp_valid = 1'b0; disp_op_id = '0; disp_is_store = 1'b0;
        disp_pc = '0; disp_rs1_val = '0; disp_rs2_val = '0; disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0;
        disp_rs1_tag = '0; disp_rs2_tag = '0; disp_imm = '0; disp_rob_id = '0;
        cdb_valid = 1'b0; cdb_rob_id = '0; cdb_value = '0; commit_valid = 1'b0; commit_rob_id = '0;
        flush = 1'b0; alu_ready = 1'b0;
        tick();
        tick();
        checkOutput("reset_valid", 64'(LSB_output_valid), 64'd0);
        checkOutput("reset_full", 64'(lsb_full), 64'd0);
        checkOutput("reset_rs1", 64'(LSB_reg_rs1), 64'd0);
        checkOutput("reset_rob", 64'(LSB_ROB_id), 64'd0);
        rst = 1'b0;

        // Ready load issues straight away, fields then hold.
        alu_ready = 1'b1;
        push_exp(OP_LW, 32'h100, 32'h1000, 32'h0, 32'd4, 4'd3);
        applyStimulus(OP_LW, 32'h100, 32'h1000, 1'b1, 4'd0, 32'h0, 1'b1, 4'd0, 32'd4, 4'd3);
        wait_drain(10);
        tick();
        tick();
        checkOutput("hold_valid", 64'(LSB_output_valid), 64'd0);
        checkOutput("hold_rs1", 64'(LSB_reg_rs1), 64'h1000);
        checkOutput("hold_rob", 64'(LSB_ROB_id), 64'd3);

        // Store waits for commit.
        applyStimulus(OP_SW, 32'h104, 32'h3000, 1'b1, 4'd0, 32'hdeadbeef, 1'b1, 4'd0, 32'd8, 4'd5);
        repeat (10) tick();
        checkOutput("sw_uncommitted_valid", 64'(LSB_output_valid), 64'd0);
        push_exp(OP_SW, 32'h104, 32'h3000, 32'hdeadbeef, 32'd8, 4'd5);
        do_commit(4'd5);
        wait_drain(10);

        // rs1 filled by a later CDB broadcast.
        push_exp(OP_LW, 32'h108, 32'h2000, 32'h0, 32'h10, 4'd6);
        applyStimulus(OP_LW, 32'h108, 32'h0, 1'b0, 4'd7, 32'h0, 1'b1, 4'd0, 32'h10, 4'd6);
        tick();
        tick();
        do_cdb(4'd7, 32'h2000);
        wait_drain(10);

        // rs1 filled by a CDB broadcast in the dispatch cycle itself.
        push_exp(OP_LW, 32'h10c, 32'h2000, 32'h0, 32'h14, 4'd8);
        cdb_valid = 1'b1; cdb_rob_id = 4'd7; cdb_value = 32'h2000;
        applyStimulus(OP_LW, 32'h10c, 32'h0, 1'b0, 4'd7, 32'h0, 1'b1, 4'd0, 32'h14, 4'd8);
        cdb_valid = 1'b0;
        wait_drain(10);

        // Store whose data operand arrives over the CDB before commit.
        applyStimulus(OP_SB, 32'h110, 32'h4000, 1'b1, 4'd0, 32'h0, 1'b0, 4'd2, 32'd1, 4'd9);
        do_cdb(4'd2, 32'h55aa);
        push_exp(OP_SB, 32'h110, 32'h4000, 32'h55aa, 32'd1, 4'd9);
        do_commit(4'd9);
        wait_drain(10);

        // Fill all 16 slots (head is mid-ring so pointers wrap); the 17th is dropped.
        alu_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_exp(OP_LH, 32'h200 + 32'(4 * i), 32'h7000 + 32'(i), 32'h0, 32'(i), 4'(i));
            applyStimulus(OP_LH, 32'h200 + 32'(4 * i), 32'h7000 + 32'(i), 1'b1, 4'd0,
                          32'h0, 1'b1, 4'd0, 32'(i), 4'(i));
        end
        checkOutput("full_after_16", 64'(lsb_full), 64'd1);
        applyStimulus(OP_LB, 32'hbad, 32'hbad, 1'b1, 4'd0, 32'h0, 1'b1, 4'd0, 32'd0, 4'd15);
        checkOutput("full_after_drop", 64'(lsb_full), 64'd1);
        alu_ready = 1'b1;
        wait_drain(60);
        tick();
        checkOutput("empty_after_drain_full", 64'(lsb_full), 64'd0);

        // Flush keeps only the committed store prefix; dispatch in the flush cycle is dropped.
        alu_ready = 1'b0;
        applyStimulus(OP_SW, 32'h300, 32'h5000, 1'b1, 4'd0, 32'h11, 1'b1, 4'd0, 32'd0, 4'd1);
        push_exp(OP_SW, 32'h300, 32'h5000, 32'h11, 32'd0, 4'd1);
        do_commit(4'd1);
        applyStimulus(OP_LW, 32'h304, 32'h5100, 1'b1, 4'd0, 32'h0, 1'b1, 4'd0, 32'd0, 4'd2);
        applyStimulus(OP_SW, 32'h308, 32'h5200, 1'b1, 4'd0, 32'h22, 1'b1, 4'd0, 32'd0, 4'd3);
        flush = 1'b1;
        applyStimulus(OP_LW, 32'h30c, 32'h5300, 1'b1, 4'd0, 32'h0, 1'b1, 4'd0, 32'd0, 4'd10);
        flush = 1'b0;
        alu_ready = 1'b1;
        wait_drain(10);
        repeat (5) tick();
        push_exp(OP_LBU, 32'h310, 32'h6000, 32'h0, 32'd2, 4'd4);
        applyStimulus(OP_LBU, 32'h310, 32'h6000, 1'b1, 4'd0, 32'h0, 1'b1, 4'd0, 32'd2, 4'd4);
        wait_drain(10);

        // Reset with five entries queued clears everything.
        alu_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(OP_LHU, 32'h500 + 32'(i), 32'h9000, 1'b1, 4'd0, 32'h0, 1'b1, 4'd0, 32'd0, 4'(i + 11));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_valid", 64'(LSB_output_valid), 64'd0);
        checkOutput("midrst_full", 64'(lsb_full), 64'd0);
        checkOutput("midrst_pc", 64'(LSB_inst_pc), 64'd0);
        checkOutput("midrst_rs1", 64'(LSB_reg_rs1), 64'd0);
        checkOutput("midrst_imm", 64'(LSB_imm), 64'd0);
        checkOutput("midrst_rob", 64'(LSB_ROB_id), 64'd0);
        alu_ready = 1'b1;
        repeat (5) tick();

        // rdy low freezes a registered pulse; it is consumed exactly once afterwards.
        push_exp(OP_LW, 32'h400, 32'ha000, 32'h0, 32'd0, 4'd1);
        applyStimulus(OP_LW, 32'h400, 32'ha000, 1'b1, 4'd0, 32'h0, 1'b1, 4'd0, 32'd0, 4'd1);
        push_exp(OP_LW, 32'h404, 32'ha004, 32'h0, 32'd0, 4'd2);
        applyStimulus(OP_LW, 32'h404, 32'ha004, 1'b1, 4'd0, 32'h0, 1'b1, 4'd0, 32'd0, 4'd2);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rdy_hold_valid", 64'(LSB_output_valid), 64'd1);
            checkOutput("rdy_hold_rob", 64'(LSB_ROB_id), 64'd1);
        end
        rdy = 1'b1;
        push_exp(OP_LW, 32'h408, 32'ha008, 32'h0, 32'd0, 4'd3);
        applyStimulus(OP_LW, 32'h408, 32'ha008, 1'b1, 4'd0, 32'h0, 1'b1, 4'd0, 32'd0, 4'd3);
        wait_drain(20);
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lsb_issue.md
Name: lsb_issue

Overview:
- Load/store buffer issue side: in-order circular queue of memory ops dispatched from decode, snooping the CDB for pending operands.
- Sends one ready head entry per transfer to the load/store ALU (ALU_LS) over its LSB_* input interface.
- Loads issue as soon as the base operand is ready; stores issue only after the ROB commits them.

Parameters:
- LSB_SIZE, 16, queue depth (power of two)
- ROB_ID_W, 4, ROB tag width
- DATA_W, 32, operand/pc width
- IMM_W, 32, immediate width
- OPID_W, 6, op identifier width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when 0 all state holds
- disp_valid  in  1  enqueue request
- disp_op_id  in  OPID_W  op (LB/LH/LW/LBU/LHU/SB/SH/SW)
- disp_is_store  in  1  entry is a store
- disp_pc  in  DATA_W  instruction pc
- disp_rs1_val, disp_rs2_val  in  DATA_W  operand values
- disp_rs1_rdy, disp_rs2_rdy  in  1  operand valid flags
- disp_rs1_tag, disp_rs2_tag  in  ROB_ID_W  producer tags when not ready
- disp_imm  in  IMM_W  offset
- disp_rob_id  in  ROB_ID_W  entry's ROB tag
- lsb_full  out  1  count == LSB_SIZE
- cdb_valid  in  1  broadcast valid
- cdb_rob_id  in  ROB_ID_W  broadcast tag
- cdb_value  in  DATA_W  broadcast value
- commit_valid  in  1  ROB commits a store
- commit_rob_id  in  ROB_ID_W  committed tag
- flush  in  1  misprediction flush
- alu_ready  in  1  ALU_LS can accept this cycle
- LSB_output_valid  out  1  one-cycle issue pulse
- LSB_OP_ID, LSB_inst_pc, LSB_reg_rs1, LSB_reg_rs2, LSB_imm, LSB_ROB_id  out  matching widths  issued fields

Behaviour:
- Reset (rst=1 at posedge): head=tail=count=0; all entries invalid; LSB_output_valid=0; all other outputs 0; lsb_full=0.
- Queue: head and tail wrap modulo LSB_SIZE; count is 0..LSB_SIZE.
- Enqueue: on disp_valid && !lsb_full, write the entry at tail. disp_valid while full is ignored with no state change.
- Dispatch-cycle CDB capture: if cdb_valid and cdb_rob_id equals a not-ready disp tag, store cdb_value and set ready.
- Snoop: every valid entry with a not-ready operand whose tag matches cdb_rob_id captures cdb_value that cycle.
- Commit: commit_valid marks the valid store entry with rob_id == commit_rob_id as committed. A commit and an issue of the same head in one cycle is legal.
- Issue: evaluated only on the head entry (strict program order).
  - Load ready: rs1 ready.
  - Store ready: rs1 and rs2 ready, and committed.
  - If ready and alu_ready, the next cycle has LSB_output_valid=1 with the head's fields registered; head advances; count decrements. Otherwise LSB_output_valid=0.
  - Issue latency: 1 cycle from the readiness condition to the valid pulse.
  - Data fields hold their last value while valid=0.
  - Operands that become ready via the CDB this cycle count as ready next cycle, not this cycle.
- Simultaneous enqueue and issue: count unchanged. An entry enqueued into an empty queue cannot issue in the same cycle.
- Flush:
  - Uncommitted entries are discarded.
  - Committed stores always form a contiguous prefix from head; they are retained.
  - tail = head + committed_count; count = committed_count.
  - Dispatch in the flush cycle is ignored.
  - A pulse already registered is still delivered.
- Priority: rst > flush > (issue, enqueue, snoop, commit concurrently).

Optional Feature:
- Macro LSB_STATS_EN.
- Defined: adds outputs stat_loads and stat_stores, 32-bit each. Each increments on every issued load/store, wraps at 2^32, resets to 0, and is not cleared by flush.
- Undefined: these ports and counters do not exist.

Decomposition:
- Shared package/defines: OPID encodings, is_store classification, DATA_W/IMM_W/ROB_ID_W widths, LSB_SIZE.
- Sub-module lsb_operand_snoop: one per operand per entry. Holds value/ready/tag and does the CDB compare and capture.

Test Plan:
- Dispatch LW (rs1 ready=0x1000, imm=4, rob 3) with alu_ready=1 -> LSB_output_valid pulses after 1 cycle, LSB_reg_rs1=0x1000, LSB_imm=4, LSB_ROB_id=3; count returns to 0.
- Dispatch SW (rob 5, operands ready), hold commit_valid=0 for 10 cycles -> no issue. Then commit rob 5 -> valid pulse the following cycle.
- Dispatch LW with rs1 tag 7 not ready, then cdb (7, 0x2000) -> issue with LSB_reg_rs1=0x2000. Repeat with the CDB in the dispatch cycle -> same result.
- Fill 16 entries with alu_ready=0 -> lsb_full=1 and a 17th dispatch is dropped. Then raise alu_ready -> 16 pulses in program order, pointers wrap correctly.
- Queue: committed SW (rob 1), uncommitted LW (rob 2), SW (rob 3), then flush -> count=1, only rob 1 issues afterward.
- Mid-operation rst with 5 entries queued -> all outputs 0 and the queue empty next cycle; rdy=0 for 3 cycles freezes state with no pulses lost or duplicated.
